hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline controller for the 5-stage core.
- Generates the stall and flush controls for every pipeline register, including pipeline_DECtoEXE.
- Generates the EXE-stage forwarding selects.
- Sequences multi-cycle data-memory miss stalls with an FSM and timeout watchdog, and keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5: register address width.
- CNT_W, 32: performance counter width.
- MISS_TIMEOUT, 256: MISS_WAIT cycles before the timeout flag sets.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- Rs1D, Rs2D  in  REG_AW  source registers in DEC.
- Rs1E, Rs2E, RdE  in  REG_AW  source/dest registers in EXE.
- ResultSrcE  in  1  EXE instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in EXE.
- RdM, RegWriteM  in  REG_AW, 1  MEM destination and write enable.
- RdW, RegWriteW  in  REG_AW, 1  WB destination and write enable.
- MissM  in  1  level; MEM access outstanding.
- ReadyM  in  1  pulse; MEM access completes this cycle.
- CntClr  in  1  synchronous counter clear.
- StallF, StallD, StallE, StallM, StallW  out  1  hold the corresponding pipeline register.
- FlushD, FlushE  out  1  load a bubble into the IF/DEC and DEC/EXE registers.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- StallCount, FlushCount  out  CNT_W  performance counters.
- MissTimeout  out  1  sticky watchdog flag.

Behaviour:
- Forwarding (combinational, all states):
  - ForwardAE = 10 if RegWriteM and RdM != 0 and RdM == Rs1E.
  - Else 01 if RegWriteW and RdW != 0 and RdW == Rs1E.
  - Else 00.
  - ForwardBE is identical using Rs2E.
  - MEM has priority over WB.
- lwStall = ResultSrcE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- FSM states: RUN, MISS_WAIT.
- RUN, MissM=1 and ReadyM=0:
  - All five stalls = 1; FlushD = FlushE = 0.
  - Next state MISS_WAIT; WaitCnt cleared.
  - Miss has priority over branch and load-use.
- RUN, MissM=1 and ReadyM=1: treated as a hit; no stall.
- RUN, otherwise:
  - StallF = StallD = lwStall; StallE = StallM = StallW = 0.
  - FlushD = PCSrcE; FlushE = lwStall or PCSrcE.
  - lwStall and PCSrcE cannot both be 1, since a load in EXE is never a branch. No priority is required between them.
- MISS_WAIT:
  - All stalls = 1, flushes = 0, while ReadyM = 0.
  - WaitCnt increments each cycle.
  - When WaitCnt reaches MISS_TIMEOUT-1, MissTimeout sets; the unit keeps waiting.
- MISS_WAIT, ReadyM=1:
  - That same cycle, stalls deassert and RUN-mode flush/stall rules apply.
  - Next state RUN.
  - A branch held in EXE during the miss keeps PCSrcE asserted, so its flush takes effect on the release cycle.
- Flush vs stall: FlushE is never asserted while StallE = 1, because the DEC/EXE register ignores flush when stalled. FlushD follows the same rule with StallD.
- StallCount:
  - Increments every cycle StallF = 1.
  - Saturates at all-ones.
- FlushCount:
  - Increments every cycle PCSrcE causes FlushE.
  - Saturates at all-ones.
- CntClr clears both counters next edge. If CntClr and an increment coincide, the clear wins.
- Reset (rst_n = 0, sampled on clk):
  - State RUN; WaitCnt, StallCount, FlushCount = 0; MissTimeout = 0.
  - While rst_n = 0, combinational outputs are forced to: stalls 0, FlushD = FlushE = 1, forwards 00. This fills the un-reset pipeline registers with bubbles.
  - Reset mid-MISS_WAIT abandons the miss immediately.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN, MISS_WAIT);
  - forward select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Forward priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10.
  - Then RegWriteM = 0 -> 01.
  - Then Rs1E = 0 with RdM = RdW = 0 -> 00.
- Load-use: ResultSrcE = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle; StallCount +1.
- Taken branch: PCSrcE = 1 in RUN -> FlushD = FlushE = 1, no stalls; FlushCount +1.
- Miss: MissM = 1 for 4 cycles, then ReadyM pulse -> all stalls 1 for 4 cycles, release on the ReadyM cycle; StallCount = 4.
- Timeout: MISS_TIMEOUT = 8, no ReadyM -> MissTimeout rises after 8 stall cycles and stays high until reset.
- Reset mid-miss: rst_n = 0 during MISS_WAIT -> next cycle state RUN, counters 0, FlushD = FlushE = 1 while rst_n is low.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit:
//               miss-sequencer state encoding and EXE forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Miss sequencer states
    typedef enum logic [0:0] {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF = 2'b00;   // register file
    localparam logic [1:0] FWD_W  = 2'b01;   // WB result
    localparam logic [1:0] FWD_M  = 2'b10;   // MEM ALU result

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//               clk   - clock
//               rst_n - synchronous active-low reset
//               clr   - clear to zero on the next edge (wins over inc)
//               inc   - increment by one, holding at all-ones
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline controller for the 5-stage core. Produces the
//               stall/flush controls for every pipeline register, the EXE
//               forwarding selects, sequences data-memory miss stalls with
//               a timeout watchdog, and keeps stall/flush counters.
//   Inputs : clk, rst_n (sync, active-low), Rs1D/Rs2D (DEC sources),
//            Rs1E/Rs2E/RdE (EXE regs), ResultSrcE (EXE load), PCSrcE
//            (taken branch in EXE), RdM/RegWriteM, RdW/RegWriteW,
//            MissM (miss outstanding), ReadyM (miss completes), CntClr.
//   Outputs: StallF..StallW, FlushD, FlushE, ForwardAE/BE,
//            StallCount, FlushCount, MissTimeout (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              MissM,
    input  logic              ReadyM,
    input  logic              CntClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount,
    output logic              MissTimeout
);

    // Wait counter only needs to reach MISS_TIMEOUT-1; it holds there.
    localparam int              WAIT_W      = $clog2(MISS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MISS_TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout;

    logic              w_lwstall;
    logic              w_miss_stall;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_stall_w;
    logic              w_flush_d, w_flush_e;
    logic [1:0]        w_fwd_a, w_fwd_b;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

    assign w_lwstall = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // A miss that completes in the cycle it is raised is a hit; in
    // MISS_WAIT the ReadyM cycle itself already runs at full speed.
    assign w_miss_stall = ((r_state == RUN) && MissM && !ReadyM) ||
                          ((r_state == MISS_WAIT) && !ReadyM);

    // Value WaitCnt takes at the next edge while a miss stall is in force.
    assign w_wait_nxt = (r_state == RUN)          ? '0 :
                        (r_wait == c_wait_last)   ? r_wait :
                                                    r_wait + WAIT_W'(1);

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_fwd_a   = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        w_fwd_b   = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

        if (!rst_n) begin
            // Flush bubbles into the pipeline registers that have no reset.
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_fwd_a   = FWD_RF;
            w_fwd_b   = FWD_RF;
        end else if (w_miss_stall) begin
            // Freeze the whole pipe; flushes stay low since stalled
            // registers would ignore them anyway.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else begin
            // A load in EXE is never a branch, so these never collide.
            w_stall_f = w_lwstall;
            w_stall_d = w_lwstall;
            w_flush_d = PCSrcE;
            w_flush_e = w_lwstall || PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (MissM && !ReadyM) begin
                        r_state <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (ReadyM) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            if (w_miss_stall) begin
                r_wait <= w_wait_nxt;
                // Sticky: stays set across further misses until reset.
                if (w_wait_nxt == c_wait_last) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_stall_f),
        .count (StallCount)
    );

    // Only branch-caused flushes count, not load-use bubbles or reset.
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (w_flush_e && PCSrcE && rst_n),
        .count (FlushCount)
    );

    assign StallF      = w_stall_f;
    assign StallD      = w_stall_d;
    assign StallE      = w_stall_e;
    assign StallM      = w_stall_m;
    assign StallW      = w_stall_w;
    assign FlushD      = w_flush_d;
    assign FlushE      = w_flush_e;
    assign ForwardAE   = w_fwd_a;
    assign ForwardBE   = w_fwd_b;
    assign MissTimeout = r_timeout;

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. Each table row is one
//               clock cycle of inputs with the expected controls; counters
//               are tracked by a small saturating model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int CW = 4;   // narrow counters so saturation is reachable
    localparam int TO = 8;

    localparam logic [6:0] c_none = 7'b0000000;
    localparam logic [6:0] c_miss = 7'b1111100;   // {SF,SD,SE,SM,SW,FD,FE}
    localparam logic [6:0] c_lw   = 7'b1100001;
    localparam logic [6:0] c_br   = 7'b0000011;

    typedef struct {
        string      name;
        logic       rstn;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       lde, pcs, rwm, rww, miss, ready, clr;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        logic       to;
        logic       chk;
        logic [CW-1:0] sc, fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MissM, ReadyM, CntClr;
    logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] StallCount, FlushCount;
    logic MissTimeout;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .CNT_W(CW), .MISS_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MissM(MissM), .ReadyM(ReadyM), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount),
        .MissTimeout(MissTimeout)
    );

    function automatic vec_t dflt(input string nm, input logic [6:0] ctl);
        vec_t v;
        v.name = nm; v.rstn = 1'b1;
        v.rs1d = 5'd0; v.rs2d = 5'd0; v.rs1e = 5'd0; v.rs2e = 5'd0;
        v.rde = 5'd0; v.rdm = 5'd0; v.rdw = 5'd0;
        v.lde = 1'b0; v.pcs = 1'b0; v.rwm = 1'b0; v.rww = 1'b0;
        v.miss = 1'b0; v.ready = 1'b0; v.clr = 1'b0;
        v.ctl = ctl; v.fa = 2'b00; v.fb = 2'b00; v.to = 1'b0; v.chk = 1'b1;
        v.sc = '0; v.fc = '0;
        return v;
    endfunction

    task automatic chk(input int row, input string nm, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL row %0d %s %s: got %0h expected %0h", row, nm, what, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;
        logic [CW-1:0] sc_m;
        logic [CW-1:0] fc_m;
        sc_m = '0;
        fc_m = '0;

        // ---- reset: forwarding-capable inputs and a miss are all masked
        v = dflt("reset", c_br); v.rstn = 1'b0; v.chk = 1'b0;
        v.rdm = 5'd5; v.rs1e = 5'd5; v.rwm = 1'b1; v.miss = 1'b1; tbl.push_back(v);
        v = dflt("reset2", c_br); v.rstn = 1'b0; tbl.push_back(v);
        // ---- forwarding priority
        v = dflt("fwd_m_pri", c_none); v.rdm = 5'd5; v.rdw = 5'd5; v.rs1e = 5'd5;
        v.rs2e = 5'd3; v.rwm = 1'b1; v.rww = 1'b1; v.fa = 2'b10; tbl.push_back(v);
        v = dflt("fwd_w", c_none); v.rdm = 5'd5; v.rdw = 5'd5; v.rs1e = 5'd5;
        v.rww = 1'b1; v.fa = 2'b01; tbl.push_back(v);
        v = dflt("fwd_x0", c_none); v.rwm = 1'b1; v.rww = 1'b1; tbl.push_back(v);
        v = dflt("fwd_b", c_none); v.rdm = 5'd6; v.rdw = 5'd6; v.rs2e = 5'd6;
        v.rs1e = 5'd1; v.rwm = 1'b1; v.rww = 1'b1; v.fb = 2'b10; tbl.push_back(v);
        // ---- load-use
        v = dflt("lw_use", c_lw); v.lde = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7; tbl.push_back(v);
        v = dflt("lw_after", c_none); v.rde = 5'd7; v.rs2d = 5'd7; tbl.push_back(v);
        v = dflt("lw_x0", c_none); v.lde = 1'b1; tbl.push_back(v);
        // ---- taken branch
        v = dflt("branch", c_br); v.pcs = 1'b1; tbl.push_back(v);
        v = dflt("idle", c_none); tbl.push_back(v);
        // ---- 4-cycle miss then release
        for (int k = 0; k < 4; k++) begin
            v = dflt("miss", c_miss); v.miss = 1'b1; tbl.push_back(v);
        end
        v = dflt("miss_rel", c_none); v.miss = 1'b1; v.ready = 1'b1; tbl.push_back(v);
        v = dflt("hit", c_none); v.miss = 1'b1; v.ready = 1'b1; tbl.push_back(v);
        // ---- branch held in EXE across a miss
        for (int k = 0; k < 2; k++) begin
            v = dflt("miss_br", c_miss); v.miss = 1'b1; v.pcs = 1'b1; tbl.push_back(v);
        end
        v = dflt("rel_br", c_br); v.miss = 1'b1; v.ready = 1'b1; v.pcs = 1'b1; tbl.push_back(v);
        // ---- load-use released out of a miss
        v = dflt("miss_lw", c_miss); v.miss = 1'b1; v.lde = 1'b1; v.rde = 5'd7;
        v.rs1d = 5'd7; tbl.push_back(v);
        v = dflt("rel_lw", c_lw); v.miss = 1'b1; v.ready = 1'b1; v.lde = 1'b1;
        v.rde = 5'd7; v.rs1d = 5'd7; tbl.push_back(v);
        v = dflt("idle2", c_none); tbl.push_back(v);
        // ---- clear coincides with a counted flush
        v = dflt("clr_br", c_br); v.clr = 1'b1; v.pcs = 1'b1; tbl.push_back(v);
        v = dflt("after_clr", c_none); tbl.push_back(v);
        // ---- watchdog and counter saturation: 20 stall cycles, no ReadyM
        for (int k = 0; k < 20; k++) begin
            v = dflt("timeout", c_miss); v.miss = 1'b1; v.to = (k >= TO); tbl.push_back(v);
        end
        // ---- reset mid-miss, then RUN with no miss must not stall
        v = dflt("rst_miss", c_br); v.rstn = 1'b0; v.miss = 1'b1; v.to = 1'b1; tbl.push_back(v);
        v = dflt("post_rst", c_none); tbl.push_back(v);
        v = dflt("final", c_none); tbl.push_back(v);

        rst_n = 1'b0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
        RdM = '0; RdW = '0; ResultSrcE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0;
        RegWriteW = 1'b0; MissM = 1'b0; ReadyM = 1'b0; CntClr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            if (i > 0) begin
                e = tbl[i-1];
                if (!e.rstn || e.clr) begin
                    sc_m = '0;
                    fc_m = '0;
                end else begin
                    if (e.ctl[6] && sc_m != {CW{1'b1}}) sc_m = sc_m + CW'(1);
                    if (e.ctl[0] && e.pcs && fc_m != {CW{1'b1}}) fc_m = fc_m + CW'(1);
                end
            end
            #1;
            v = tbl[i];
            rst_n = v.rstn; Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e;
            Rs2E = v.rs2e; RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
            ResultSrcE = v.lde; PCSrcE = v.pcs; RegWriteM = v.rwm;
            RegWriteW = v.rww; MissM = v.miss; ReadyM = v.ready; CntClr = v.clr;
            v.sc = sc_m;
            v.fc = fc_m;
            sb.push_back(v);

            @(negedge clk);
            if (sb.size() == 0) begin
                chk(i, "scoreboard", "empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(i, e.name, "ctl",
                    {25'd0, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE},
                    {25'd0, e.ctl});
                chk(i, e.name, "ForwardAE", {30'd0, ForwardAE}, {30'd0, e.fa});
                chk(i, e.name, "ForwardBE", {30'd0, ForwardBE}, {30'd0, e.fb});
                if (e.chk) begin
                    chk(i, e.name, "StallCount", {28'd0, StallCount}, {28'd0, e.sc});
                    chk(i, e.name, "FlushCount", {28'd0, FlushCount}, {28'd0, e.fc});
                    chk(i, e.name, "MissTimeout", {31'd0, MissTimeout}, {31'd0, e.to});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_unit
`default_nettype wire
